// File: rtl/vip_pkg.sv
// Shared video-pipeline definitions: pixel width, default line length and
// the column record that the 3x3 window shifts through.
package vip_pkg;

    localparam int PIX_W         = 8;
    localparam int IMG_WIDTH_DEF = 1280;

    typedef struct packed {
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] bot;
    } win_col_t;

endpackage

// File: rtl/line_buffer_ram.sv
// Single-port line store with registered read-before-write access.
// Contents are deliberately not reset.
module line_buffer_ram #(
    parameter int DEPTH  = 1280,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rd_data <= mem[addr];
            if (we) begin
                mem[addr] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/line_window_3x3.sv
// 3x3 neighbourhood generator for a raster luma stream; the window is
// zero-filled at the top and left image borders.
module line_window_3x3
    import vip_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int DATA_W    = PIX_W,
    parameter int COL_W     = $clog2(IMG_WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_de,
    input  logic [DATA_W-1:0] per_img_y,
    output logic              matrix_frame_vsync,
    output logic              matrix_frame_href,
    output logic              matrix_frame_clken,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33
);

    localparam int               ADDR_W  = $clog2(IMG_WIDTH);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH);

    logic              href_d, vsync_d;
    logic              href_fall, vsync_rise;
    logic              accept;
    logic [COL_W-1:0]  col_cnt;
    logic [1:0]        row_cnt;
    logic              line_sel;
    logic [DATA_W-1:0] lb1_q, lb2_q;

    logic [DATA_W-1:0] pix_p1;
    logic [COL_W-1:0]  col_p1;
    logic [1:0]        row_p1;
    logic              sel_p1, vld_p1, vsync_p1, href_p1;

    win_col_t          new_col;
    win_col_t          win_c1, win_c2, win_c3;
    logic              vld_p2, vsync_p2, href_p2;

    assign href_fall  = href_d & ~per_frame_href;
    assign vsync_rise = per_frame_vsync & ~vsync_d;
    assign accept     = per_frame_de && (col_cnt < COL_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_d   <= 1'b0;
            vsync_d  <= 1'b0;
            col_cnt  <= '0;
            row_cnt  <= 2'd0;
            line_sel <= 1'b0;
        end else begin
            href_d  <= per_frame_href;
            vsync_d <= per_frame_vsync;
            if (href_fall) begin
                col_cnt <= '0;
            end else if (per_frame_de && per_frame_href && (col_cnt < COL_MAX)) begin
                col_cnt <= col_cnt + 1'b1;
            end
            // A frame start overrides a line end landing on the same cycle.
            if (vsync_rise) begin
                row_cnt  <= 2'd0;
                line_sel <= 1'b0;
            end else if (href_fall && (col_cnt != '0)) begin
                if (row_cnt != 2'd2) begin
                    row_cnt <= row_cnt + 2'd1;
                end
                line_sel <= ~line_sel;
            end
        end
    end

    // The two buffers take alternate lines: the buffer being overwritten
    // returns the line two up, the other returns the line one up.
    line_buffer_ram #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_lb1 (
        .clk     (clk),
        .en      (accept),
        .we      (accept & ~line_sel),
        .addr    (col_cnt[ADDR_W-1:0]),
        .wr_data (per_img_y),
        .rd_data (lb1_q)
    );

    line_buffer_ram #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_lb2 (
        .clk     (clk),
        .en      (accept),
        .we      (accept & line_sel),
        .addr    (col_cnt[ADDR_W-1:0]),
        .wr_data (per_img_y),
        .rd_data (lb2_q)
    );

    // Stage 1: line-buffer access and input capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_p1   <= '0;
            col_p1   <= '0;
            row_p1   <= 2'd0;
            sel_p1   <= 1'b0;
            vld_p1   <= 1'b0;
            vsync_p1 <= 1'b0;
            href_p1  <= 1'b0;
        end else begin
            vld_p1   <= accept;
            vsync_p1 <= per_frame_vsync;
            href_p1  <= per_frame_href;
            if (accept) begin
                pix_p1 <= per_img_y;
                col_p1 <= col_cnt;
                row_p1 <= row_cnt;
                sel_p1 <= line_sel;
            end
        end
    end

    always_comb begin
        new_col     = '0;
        new_col.bot = pix_p1;
        if (row_p1 == 2'd2) begin
            new_col.top = sel_p1 ? lb2_q : lb1_q;
        end
        if (row_p1 != 2'd0) begin
            new_col.mid = sel_p1 ? lb1_q : lb2_q;
        end
    end

    // Stage 2: window shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_c1   <= '0;
            win_c2   <= '0;
            win_c3   <= '0;
            vld_p2   <= 1'b0;
            vsync_p2 <= 1'b0;
            href_p2  <= 1'b0;
        end else begin
            vld_p2   <= vld_p1;
            vsync_p2 <= vsync_p1;
            href_p2  <= href_p1;
            if (vld_p1) begin
                if (col_p1 == '0) begin
                    win_c1 <= '0;
                    win_c2 <= '0;
                end else begin
                    win_c1 <= win_c2;
                    win_c2 <= win_c3;
                end
                win_c3 <= new_col;
            end
        end
    end

    assign matrix_frame_vsync = vsync_p2;
    assign matrix_frame_href  = href_p2;
    assign matrix_frame_clken = vld_p2;
    assign matrix_p11 = win_c1.top;
    assign matrix_p12 = win_c2.top;
    assign matrix_p13 = win_c3.top;
    assign matrix_p21 = win_c1.mid;
    assign matrix_p22 = win_c2.mid;
    assign matrix_p23 = win_c3.mid;
    assign matrix_p31 = win_c1.bot;
    assign matrix_p32 = win_c2.bot;
    assign matrix_p33 = win_c3.bot;

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 with a small image model feeding a
// scoreboard of expected windows and their arrival cycles.
module tb_line_window_3x3;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href = 1'b0;
    logic       per_frame_de = 1'b0;
    logic [7:0] per_img_y = 8'd0;
    logic       matrix_frame_vsync, matrix_frame_href, matrix_frame_clken;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;

    line_window_3x3 #(.IMG_WIDTH(W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .per_frame_vsync    (per_frame_vsync),
        .per_frame_href     (per_frame_href),
        .per_frame_de       (per_frame_de),
        .per_img_y          (per_img_y),
        .matrix_frame_vsync (matrix_frame_vsync),
        .matrix_frame_href  (matrix_frame_href),
        .matrix_frame_clken (matrix_frame_clken),
        .matrix_p11         (matrix_p11),
        .matrix_p12         (matrix_p12),
        .matrix_p13         (matrix_p13),
        .matrix_p21         (matrix_p21),
        .matrix_p22         (matrix_p22),
        .matrix_p23         (matrix_p23),
        .matrix_p31         (matrix_p31),
        .matrix_p32         (matrix_p32),
        .matrix_p33         (matrix_p33)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [71:0] win;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          nclk = 0;
    int          n0;
    logic [7:0]  l0[W], l1[W], l2[W];
    int          m_col = 0;
    int          m_rows = 0;
    logic [71:0] last_win = '0;
    logic        vs_h1 = 1'b0, vs_h2 = 1'b0, hr_h1 = 1'b0, hr_h2 = 1'b0;
    exp_t        mon_e;
    logic        mon_due;

    wire [71:0] win_o = {matrix_p11, matrix_p12, matrix_p13,
                         matrix_p21, matrix_p22, matrix_p23,
                         matrix_p31, matrix_p32, matrix_p33};
    wire [79:0] all_o = {5'd0, matrix_frame_vsync, matrix_frame_href,
                         matrix_frame_clken, win_o};

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected window from the image model: row k lines up, column offset
    // back from c; anything above the accumulated rows or left of col 0 is 0.
    function automatic logic [71:0] model_win(input int c);
        logic [71:0] w;
        logic [7:0]  v;
        w = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                int k;
                int col;
                k   = 2 - rr;
                col = c - 2 + cc;
                v   = 8'd0;
                if (col >= 0 && k <= m_rows) begin
                    v = (k == 0) ? l0[col] : (k == 1) ? l1[col] : l2[col];
                end
                w = {w[63:0], v};
            end
        end
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_win = '0;
            vs_h1 = 1'b0; vs_h2 = 1'b0; hr_h1 = 1'b0; hr_h2 = 1'b0;
        end else begin
            chk("vsync_delay", 80'(matrix_frame_vsync), 80'(vs_h2));
            chk("href_delay", 80'(matrix_frame_href), 80'(hr_h2));
            vs_h2 = vs_h1; vs_h1 = per_frame_vsync;
            hr_h2 = hr_h1; hr_h1 = per_frame_href;
            mon_due = (sb.size() > 0) && (sb[0].cyc <= cyc);
            chk("clken", 80'(matrix_frame_clken), 80'(mon_due));
            if (matrix_frame_clken) begin
                nclk++;
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("window", 80'(win_o), 80'(mon_e.win));
                    last_win = mon_e.win;
                end
            end else begin
                chk("window_hold", 80'(win_o), 80'(last_win));
                if (mon_due) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] v, input bit dir, input logic [71:0] dwin);
        exp_t e;
        per_frame_de = 1'b1;
        per_img_y    = v;
        if (m_col < W) begin
            l0[m_col] = v;
            e.cyc = cyc + 2;
            e.win = dir ? dwin : model_win(m_col);
            sb.push_back(e);
            m_col++;
        end
        tick();
        per_frame_de = 1'b0;
    endtask

    task automatic end_line();
        per_frame_href = 1'b0;
        per_frame_de   = 1'b0;
        tick();
        if (m_col > 0) begin
            l2 = l1;
            l1 = l0;
            if (m_rows < 2) m_rows++;
        end
        m_col = 0;
        repeat (2) tick();
    endtask

    task automatic do_line(input int base, input int step, input int n, input int gap_at,
                           input int dcol, input logic [71:0] dwin);
        per_frame_href = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                per_frame_de = 1'b0;
                repeat (3) tick();
            end
            send_pixel(8'(base + step * i), i == dcol, dwin);
        end
        end_line();
    endtask

    task automatic start_frame();
        per_frame_vsync = 1'b1;
        tick();
        per_frame_vsync = 1'b0;
        tick();
        m_rows = 0;
        m_col  = 0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) tick();
        chk("reset_outputs", all_o, 80'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Frame 1: 3 lines of 16*r+c+1
        start_frame();
        n0 = nclk;
        do_line(1, 1, 4, -1, 0, 72'h00_00_00_00_00_00_00_00_01);
        do_line(17, 1, 4, -1, 1, 72'h00_00_00_00_01_02_00_11_12);
        do_line(33, 1, 4, -1, 2, 72'h01_02_03_11_12_13_21_22_23);
        chk("frame_clkens", 80'(nclk - n0), 80'd12);

        // Frame 2: over-length line then a normal line
        start_frame();
        n0 = nclk;
        do_line(50, 1, 6, -1, -1, '0);
        chk("overlen_clkens", 80'(nclk - n0), 80'd4);
        do_line(60, 1, 4, -1, 3, 72'h00_00_00_33_34_35_3D_3E_3F);

        // Frame 3: all 200, stale RAM must stay masked
        start_frame();
        do_line(200, 0, 4, -1, 3, 72'h00_00_00_00_00_00_C8_C8_C8);
        do_line(200, 0, 4, -1, 3, 72'h00_00_00_C8_C8_C8_C8_C8_C8);
        do_line(200, 0, 4, -1, 0, 72'h00_00_C8_00_00_C8_00_00_C8);

        // Frame 4: asynchronous reset mid-line, then lines with de gaps
        start_frame();
        per_frame_href = 1'b1;
        send_pixel(8'd90, 1'b0, '0);
        send_pixel(8'd91, 1'b0, '0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_reset", all_o, 80'd0);
        sb.delete();
        m_rows = 0;
        m_col  = 0;
        per_frame_href = 1'b0;
        per_frame_de   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        do_line(100, 1, 4, 2, 3, 72'h00_00_00_00_00_00_65_66_67);
        do_line(110, 1, 4, 1, 2, 72'h00_00_00_64_65_66_6E_6F_70);
        do_line(120, 1, 4, 3, -1, '0);

        repeat (5) tick();
        chk("scoreboard_drained", 80'(sb.size()), 80'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
